// File: rtl/axi4_lite_cmd_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axi4_lite_cmd_arbiter_if
// Purpose  : Command port between the arbiter and the AXI4-Lite master.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface axi4_lite_cmd_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_addr;
    logic              m_write;
    logic [DATA_W-1:0] m_wdata;
    logic              m_transfer;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport master (
        output m_addr,
        output m_write,
        output m_wdata,
        output m_transfer,
        input  m_rdata,
        input  m_ready
    );

    modport slave (
        input  m_addr,
        input  m_write,
        input  m_wdata,
        input  m_transfer,
        output m_rdata,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_cmd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axi4_lite_cmd_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4-Lite command port.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module axi4_lite_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic                      ACLK,
    input  wire logic                      ARESET,
    input  wire logic [NUM_REQ-1:0]        req,
    input  wire logic [NUM_REQ-1:0]        req_write,
    input  wire logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  wire logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic      [NUM_REQ-1:0]        gnt,
    output logic      [NUM_REQ-1:0]        done,
    output logic      [DATA_W-1:0]         resp_rdata,
    output logic                           resp_err,
    output logic                           busy,
    axi4_lite_cmd_arbiter_if.master        m
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_winner;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_found;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_timeout;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC));

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int j;
        j         = 0;
        w_found   = 1'b0;
        w_win_idx = r_rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req[IDX_W'(j)]) begin
                w_found   = 1'b1;
                w_win_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (m.m_ready || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_win_idx;
                        r_write  <= req_write[w_win_idx];
                        r_addr   <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
                        r_wdata  <= req_wdata[w_win_idx*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // Counter stops at TIMEOUT_CYC because WAIT is left there.
                    if (m.m_ready) begin
                        if (!r_write) begin
                            r_rdata <= m.m_rdata;
                        end
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= (r_winner == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : r_winner + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (r_state != S_IDLE) begin
            gnt[r_winner] = 1'b1;
        end
        if (r_state == S_DONE) begin
            done[r_winner] = 1'b1;
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign m.m_addr     = r_addr;
    assign m.m_write    = r_write;
    assign m.m_wdata    = r_wdata;
    assign m.m_transfer = (r_state == S_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_axi4_lite_cmd_arbiter
// Purpose  : Scoreboard bench for the round-robin command arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_axi4_lite_cmd_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      resp_err;
    logic                      busy;

    axi4_lite_cmd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    axi4_lite_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .m(m_if)
    );

    typedef struct { int idx; logic wr; logic [3:0] addr; logic [31:0] wdata; } xfer_t;
    typedef struct { int idx; logic err; logic [31:0] rdata; int lat; } done_t;

    xfer_t       xfer_q[$];
    done_t       done_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata;
    logic [31:0] rdata_base;
    int          ready_delay;
    int          ready_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_cmd(input int idx, input logic wr, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic tmo, input logic want_done);
        xfer_t x;
        done_t d;
        req_write[idx]        = wr;
        req_addr[idx*4 +: 4]   = addr;
        req_wdata[idx*32 +: 32] = wdata;
        x.idx = idx; x.wr = wr; x.addr = addr; x.wdata = wdata;
        xfer_q.push_back(x);
        if (want_done) begin
            if (!tmo && !wr) exp_rdata = rdata_base ^ {28'h0, addr};
            d.idx   = idx;
            d.err   = tmo;
            d.rdata = exp_rdata;
            d.lat   = tmo ? TIMEOUT_CYC + 2 : ready_delay + 1;
            done_q.push_back(d);
        end
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done != '0) begin
                for (int i = 0; i < NUM_REQ; i++) if (done[i]) idx = i;
                break;
            end
        end
        if (idx < 0) check("wait_done_timeout", 0, 1);
    endtask

    // Master model: ready_delay cycles after ISSUE, ready for ready_hold cycles.
    initial begin
        int cnt;
        int hold_left;
        cnt = 0;
        hold_left = 0;
        m_if.m_ready = 1'b0;
        m_if.m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                hold_left = 0;
                m_if.m_ready = 1'b0;
            end else begin
                if (hold_left > 0) begin
                    m_if.m_ready = 1'b1;
                    hold_left--;
                end else begin
                    m_if.m_ready = 1'b0;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_if.m_ready = 1'b1;
                        m_if.m_rdata = rdata_base ^ {28'h0, m_if.m_addr};
                        hold_left    = ready_hold - 1;
                    end
                end
                if (m_if.m_transfer && ready_delay > 0) cnt = ready_delay;
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer and every done pulse.
    initial begin
        int          cyc;
        int          issue_cyc;
        xfer_t       x;
        done_t       d;
        logic [3:0]  e;
        cyc = 0;
        issue_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            check("gnt_onehot0", 64'($onehot0(gnt)), 1);
            check("busy_vs_gnt", busy, |gnt);
            if (m_if.m_transfer) begin
                issue_cyc = cyc;
                if (xfer_q.size() == 0) begin
                    check("xfer_unexpected", 1, 0);
                end else begin
                    x = xfer_q.pop_front();
                    e = '0; e[x.idx] = 1'b1;
                    check("xfer_gnt", gnt, e);
                    check("xfer_addr", m_if.m_addr, x.addr);
                    check("xfer_write", m_if.m_write, x.wr);
                    check("xfer_wdata", m_if.m_wdata, x.wdata);
                end
            end
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    d = done_q.pop_front();
                    e = '0; e[d.idx] = 1'b1;
                    check("done_vec", done, e);
                    check("done_gnt", gnt, e);
                    check("resp_err", resp_err, d.err);
                    check("resp_rdata", resp_rdata, d.rdata);
                    check("done_latency", cyc - issue_cyc, d.lat);
                end
            end
        end
    end

    initial begin
        int idx;
        rst = 1'b1;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rdata_base = '0; exp_rdata = '0;
        ready_delay = 2; ready_hold = 1;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_transfer", m_if.m_transfer, 0);
        check("rst_write", m_if.m_write, 0);
        check("rst_err", resp_err, 0);
        check("rst_addr", m_if.m_addr, 0);
        check("rst_wdata", m_if.m_wdata, 0);
        check("rst_rdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // single write, ready 3 cycles after ISSUE
        ready_delay = 3;
        load_cmd(1, 1'b1, 4'h8, 32'hDEADBEEF, 1'b0, 1'b1);
        req[1] = 1'b1;
        wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        @(negedge clk);

        // single read with ready held three cycles
        ready_delay = 1; ready_hold = 3; rdata_base = 32'h1234567C;
        load_cmd(2, 1'b0, 4'h4, 32'h0, 1'b0, 1'b1);
        req[2] = 1'b1;
        wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        check("read_value", resp_rdata, 32'h12345678);
        ready_hold = 1;
        repeat (3) @(negedge clk);

        // rotation: pointer is now 3, so 3 goes before 0
        ready_delay = 2; rdata_base = 32'h0BAD0000;
        load_cmd(3, 1'b0, 4'hA, 32'h0, 1'b0, 1'b1);
        load_cmd(0, 1'b1, 4'h2, 32'h55AA55AA, 1'b0, 1'b1);
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        end
        @(negedge clk);

        // reset during WAIT
        ready_delay = 0;
        load_cmd(1, 1'b1, 4'h6, 32'hCAFEF00D, 1'b0, 1'b0);
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_busy", busy, 0);
        req = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        check("post_rst_rdata", resp_rdata, 0);
        ready_delay = 2; rdata_base = 32'h00F0F000;
        load_cmd(3, 1'b0, 4'hC, 32'h0, 1'b0, 1'b1);
        req[3] = 1'b1;
        wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        @(negedge clk);

        // contention: all four, order 0,1,2,3
        rdata_base = 32'h77770000;
        for (int i = 0; i < NUM_REQ; i++)
            load_cmd(i, i[0], 4'(i * 2 + 1), 32'hA0000000 + i, 1'b0, 1'b1);
        req = 4'b1111;
        for (int n = 0; n < NUM_REQ; n++) begin
            wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        end
        @(negedge clk);

        // timeout then a normal command
        ready_delay = 0;
        load_cmd(0, 1'b1, 4'h3, 32'h00000001, 1'b1, 1'b1);
        req[0] = 1'b1;
        wait_done(idx); if (idx >= 0) req[idx] = 1'b0;
        @(negedge clk);
        ready_delay = 2; rdata_base = 32'h31415920;
        load_cmd(2, 1'b0, 4'h5, 32'h0, 1'b0, 1'b1);
        req[2] = 1'b1;
        wait_done(idx); if (idx >= 0) req[idx] = 1'b0;

        repeat (3) @(negedge clk);
        check("xfer_q_left", xfer_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
